// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling 8N1 UART receiver feeding a first-word fall-through FIFO
module uart_rx_fifo #(
  parameter int CLK_PER_TICK = 651,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     rx_avail,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     overrun,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_PER_TICK);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_PER_TICK - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          sync1_q, sync2_q, rxs;
  logic [TW-1:0] tcnt_q;
  logic          tick;
  state_e        state_q, state_d;
  logic [3:0]    ph_q, ph_d;
  logic [2:0]    bc_q, bc_d;
  logic [7:0]    sr_q, sr_d;
  logic          s6_q, s6_d, s7_q, s7_d, maj;
  logic          push, ferr_set;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          overrun_q, frame_err_q;
  logic          pop, full, wr, ovr_set;

  assign rxs  = sync2_q;
  assign tick = (tcnt_q == TICK_MAX);
  assign maj  = (s6_q & s7_q) | (s6_q & rxs) | (s7_q & rxs);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tcnt_q  <= '0;
      state_q <= S_IDLE;
      ph_q    <= '0;
      bc_q    <= '0;
      sr_q    <= '0;
      s6_q    <= 1'b0;
      s7_q    <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      tcnt_q  <= tick ? '0 : tcnt_q + TW'(1);
      state_q <= state_d;
      ph_q    <= ph_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
      s6_q    <= s6_d;
      s7_q    <= s7_d;
    end
  end

  // ph is 4 bits, so it wraps 15->0 by itself between data bits
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bc_d    = bc_q;
    sr_d    = sr_q;
    s6_d    = s6_q;
    s7_d    = s7_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            ph_d    = 4'd0;
            state_d = S_START;
          end
        end
        S_START: begin
          ph_d = ph_q + 4'd1;
          if (ph_q == 4'd7 && rxs) begin
            state_d = S_IDLE;
          end else if (ph_q == 4'd15) begin
            ph_d    = 4'd0;
            bc_d    = 3'd0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          ph_d = ph_q + 4'd1;
          if (ph_q == 4'd6) s6_d = rxs;
          if (ph_q == 4'd7) s7_d = rxs;
          if (ph_q == 4'd8) sr_d = {maj, sr_q[7:1]};
          if (ph_q == 4'd15) begin
            if (bc_q == 3'd7) begin
              ph_d    = 4'd0;
              state_d = S_STOP;
            end else begin
              bc_d = bc_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          ph_d = ph_q + 4'd1;
          if (ph_q == 4'd7) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (tick && state_q == S_STOP && ph_q == 4'd7) begin
      push     = rxs;
      ferr_set = !rxs;
    end
  end

  // a pop in the push cycle frees the slot, so a full FIFO still accepts the byte
  assign pop     = rd_en && (count_q != '0);
  assign full    = (count_q == FULL_CNT);
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !rd_en;

  always_ff @(posedge clk) begin
    if (wr) mem_q[tail_q] <= sr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr)  tail_q <= tail_q + AW'(1);
      if (pop) head_q <= head_q + AW'(1);
      if (wr && !pop)      count_q <= count_q + CW'(1);
      else if (!wr && pop) count_q <= count_q - CW'(1);
      if (ovr_set)      overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
      if (ferr_set)     frame_err_q <= 1'b1;
      else if (clr_err) frame_err_q <= 1'b0;
    end
  end

  assign rx_avail  = (count_q != '0);
  assign rx_count  = count_q;
  assign rd_data   = rx_avail ? mem_q[head_q] : 8'h00;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rx_avail, overrun, frame_err;
  logic [3:0] rx_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int rise1, rise;
  logic [31:0] snap_cnt, snap_data, snap_avail, snap_ovr, snap_fe;

  uart_rx_fifo #(.CLK_PER_TICK(4), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_avail(rx_avail), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // start every frame on the same tick phase so push timing repeats exactly
  task automatic align();
    do begin @(posedge clk); #1; end while (((cyc - rst_cyc) % 4) != 0);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                            input int rst_at, output int rise_c);
    logic [9:0] fr;
    logic [3:0] cnt0;
    fr = {stop, b, 1'b0};
    align();
    cnt0 = rx_count;
    rise_c = -1;
    for (int c = 0; c < 640; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rise_c < 0 && rx_count != cnt0) rise_c = c;
      if (c == rst_at + 1) begin
        reset = 1'b0;
        rst_cyc = cyc;
        snap_cnt = 32'(rx_count); snap_data = 32'(rd_data); snap_avail = 32'(rx_avail);
        snap_ovr = 32'(overrun); snap_fe = 32'(frame_err);
      end
      if (c == rst_at) reset = 1'b1;
      rx    = fr[c / 64];
      rd_en = (c == pop_at);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    do_reset();
    chk("reset_rd_data", 32'(rd_data), 32'h00);
    chk("reset_rx_avail", 32'(rx_avail), 32'd0);
    chk("reset_rx_count", 32'(rx_count), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    idle(20);

    // 1: single frame
    send_frame(8'h55, 1'b1, -1, -1000, rise1);
    chk("t1_rise_window", 32'(rise1 >= 600 && rise1 <= 620), 32'd1);
    chk("t1_rd_data", 32'(rd_data), 32'h55);
    chk("t1_rx_count", 32'(rx_count), 32'd1);
    chk("t1_rx_avail", 32'(rx_avail), 32'd1);
    pop();
    chk("t1_count_after_pop", 32'(rx_count), 32'd0);
    chk("t1_data_after_pop", 32'(rd_data), 32'h00);
    chk("t1_avail_after_pop", 32'(rx_avail), 32'd0);
    pop();
    chk("t1_empty_pop_count", 32'(rx_count), 32'd0);
    chk("t1_empty_pop_ovr", 32'(overrun), 32'd0);
    idle(10);

    // 2: 16-clock glitch, then a clean frame right after the bit period
    align();
    rx = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    rx = 1'b1;
    repeat (44) begin @(posedge clk); #1; end
    chk("t2_glitch_count", 32'(rx_count), 32'd0);
    chk("t2_glitch_ferr", 32'(frame_err), 32'd0);
    send_frame(8'h96, 1'b1, -1, -1000, rise);
    chk("t2_next_data", 32'(rd_data), 32'h96);
    chk("t2_next_count", 32'(rx_count), 32'd1);
    pop();
    idle(10);

    // 3: framing error
    send_frame(8'hA3, 1'b0, -1, -1000, rise);
    idle(64);
    chk("t3_ferr_count", 32'(rx_count), 32'd0);
    chk("t3_ferr_set", 32'(frame_err), 32'd1);
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    chk("t3_ferr_cleared", 32'(frame_err), 32'd0);
    send_frame(8'h5A, 1'b1, -1, -1000, rise);
    chk("t3_clean_data", 32'(rd_data), 32'h5A);
    chk("t3_clean_count", 32'(rx_count), 32'd1);
    chk("t3_clean_ferr", 32'(frame_err), 32'd0);
    pop();
    idle(10);

    // 4: overrun with nine back-to-back frames
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, -1, -1000, rise);
    chk("t4_count_full", 32'(rx_count), 32'd8);
    chk("t4_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_pop_order", 32'(rd_data), 32'(i));
      pop();
    end
    chk("t4_count_empty", 32'(rx_count), 32'd0);
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    chk("t4_overrun_cleared", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_frame(8'hC0 + 8'(i), 1'b1, -1, -1000, rise);
      chk("t4_wrap_data", 32'(rd_data), 32'hC0 + 32'(i));
      chk("t4_wrap_count", 32'(rx_count), 32'd1);
      pop();
    end
    idle(10);

    // 5: full FIFO with a pop on the exact push clock
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1000, rise);
    chk("t5_count_full", 32'(rx_count), 32'd8);
    send_frame(8'hEE, 1'b1, rise1 - 1, -1000, rise);
    chk("t5_count_kept", 32'(rx_count), 32'd8);
    chk("t5_no_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i < 8; i++) begin
      chk("t5_pop_order", 32'(rd_data), 32'h10 + 32'(i));
      pop();
    end
    chk("t5_last_byte", 32'(rd_data), 32'hEE);
    pop();
    chk("t5_count_empty", 32'(rx_count), 32'd0);
    idle(10);

    // 6: reset during bit 4 with 3 bytes queued and frame_err set
    for (int i = 0; i < 3; i++) send_frame(8'h31 + 8'(i), 1'b1, -1, -1000, rise);
    send_frame(8'h00, 1'b0, -1, -1000, rise);
    idle(64);
    chk("t6_pre_count", 32'(rx_count), 32'd3);
    chk("t6_pre_ferr", 32'(frame_err), 32'd1);
    send_frame(8'hF0, 1'b1, -1, 350, rise);
    chk("t6_rst_count", snap_cnt, 32'd0);
    chk("t6_rst_data", snap_data, 32'h00);
    chk("t6_rst_avail", snap_avail, 32'd0);
    chk("t6_rst_overrun", snap_ovr, 32'd0);
    chk("t6_rst_ferr", snap_fe, 32'd0);
    idle(64);
    chk("t6_no_push", 32'(rx_count), 32'd0);
    chk("t6_no_ferr", 32'(frame_err), 32'd0);
    send_frame(8'h3C, 1'b1, -1, -1000, rise);
    chk("t6_after_data", 32'(rd_data), 32'h3C);
    chk("t6_after_count", 32'(rx_count), 32'd1);
    pop();
    chk("t6_final_count", 32'(rx_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Standalone UART receive front end: oversamples the asynchronous serial input at 16× baud, deframes 8N1 characters and buffers them in a small FIFO.
- Sits between the board's serial input pin and the peripheral register file.
- Replaces single-byte capture with a buffered, flag-reporting source, so back-to-back characters are not lost while the CPU is busy.
- The register file pops bytes with a one-cycle read strobe.

## Interface
Parameters:
- CLK_PER_TICK, 651, system clocks per 16× oversample tick (100 MHz / 9600 / 16); minimum 2
- DEPTH, 8, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- rx  in  1  serial input, asynchronous, idle high
- rd_en  in  1  pop strobe, one byte per asserted cycle
- clr_err  in  1  clears overrun and frame_err
- rd_data  out  8  FIFO head (first-word fall-through); 8'h00 when empty
- rx_avail  out  1  FIFO not empty
- rx_count  out  log2(DEPTH)+1  bytes held
- overrun  out  1  sticky: byte dropped because FIFO full
- frame_err  out  1  sticky: stop bit sampled low

## Operation
- **Input synchronizer:** rx passes through a 2-FF synchronizer; both flops reset to 1. All decisions use the synchronized value rxs.
- **Tick generator:** free-running counter, 0..CLK_PER_TICK-1. tick is a one-clock pulse when the counter equals CLK_PER_TICK-1. The counter is cleared by reset only.
- **Frame state:** phase counter ph (4 bits, counts ticks within a bit) and bit counter bc (3 bits).
- **IDLE:**
  - On a tick with rxs==0: ph←0, go to START.
  - Otherwise stay.
- **START:**
  - On each tick, ph increments.
  - At the tick where ph==7: if rxs==1 this is a false start; return to IDLE with no flag set.
  - At the tick where ph==15: ph←0, bc←0, go to DATA.
- **DATA:**
  - The bit value is the majority of rxs sampled at ph==6, 7 and 8.
  - At ph==8 the bit is shifted into the shift register LSB-first: sr←{bit, sr[7:1]}.
  - At ph==15: if bc==7, ph←0 and go to STOP; else bc increments.
- **STOP:**
  - At ph==7, sample rxs.
  - If rxs==1: push sr.
  - If rxs==0: set frame_err and discard the byte.
  - Either way return to IDLE in the same clock, so the next start edge can be detected within the remaining half stop bit.
- **Push:**
  - If the FIFO is not full, write sr at the tail and advance it.
  - If the FIFO is full and rd_en is low, drop the byte and set overrun.
  - If the FIFO is full and rd_en is high in the same cycle, accept both the pop and the push. rx_count is unchanged and overrun is not set.
- **Pop:**
  - rd_en with rx_avail==1 advances the head.
  - rd_en on an empty FIFO is ignored. No flag is set and rx_count stays 0.
- **Pointers:** head and tail are log2(DEPTH) bits wide and wrap modulo DEPTH.
- **Occupancy:** rx_count = pushes − pops, always within 0..DEPTH.
- **Flag clearing:**
  - clr_err clears overrun and frame_err.
  - If a set event and clr_err occur in the same cycle, set wins.
- **Reset (asserted at any time, including mid-frame):**
  - FSM→IDLE; ph, bc, sr, tick counter←0.
  - FIFO emptied (head = tail = 0).
  - overrun, frame_err←0; synchronizer←1.
  - A partially received frame is discarded.

## Timing
- Output values during/after reset: rd_data=8'h00, rx_avail=0, rx_count=0, overrun=0, frame_err=0.
- Start-edge detection uncertainty:
  - rxs lags rx by 2 clocks.
  - Start detection additionally waits up to one tick (CLK_PER_TICK clocks).
- Bit length: 16 ticks.
- Sample point: the centre of each bit, tick-aligned to the detected start.
- Push point: the push occurs on the clock of the stop-bit ph==7 tick.
  - rx_avail, rx_count and rd_data update on the following clock edge, i.e. they are visible 1 clock after the push tick.
- Pop: rd_data shows the next entry 1 clock after the rd_en cycle; rx_count decrements on the same edge.
- All outputs are registered or derive combinationally from registered head/tail/mem only. rd_data has no combinational path from rx.

## Test plan
All scenarios use CLK_PER_TICK=4, DEPTH=8, so one bit = 64 clocks.

1. **Single frame:** drive 0x55 as 8N1 → rx_avail rises between clock 600 and 620 after the start edge; rd_data=0x55, rx_count=1. Pulse rd_en → rx_count=0 and rd_data=0x00.
2. **Glitch rejection:** drive rx low for 16 clocks, then high → no push, rx_count=0, frame_err=0, and the FSM is back in IDLE before the 64th clock.
3. **Framing error:** send 0xA3 with the stop bit held low → rx_count stays 0 and frame_err=1. Pulse clr_err → frame_err=0. A following clean 0x5A frame is received correctly.
4. **Overrun:** send 9 back-to-back frames 0x00..0x08 with no reads → rx_count=8, overrun=1. Eight pops return 0x00..0x07 in order; pointer wrap is checked by a further 4 push/pop pairs.
5. **Full plus same-cycle pop:** fill 8 entries, then assert rd_en on the exact push clock of a 9th byte 0xEE → rx_count stays 8, overrun=0, and 0xEE is the last byte read out.
6. **Reset mid-frame:** assert reset for 1 clock during bit 4 of a frame with 3 bytes queued → all outputs at reset values. The remainder of the interrupted frame produces no push. A following 0x3C frame is received and is the only entry.
